fifo_tx_fetch: RTL and testbench
================================

FIFO_TX_FETCH -- requirements
Module: fifo_tx_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO read data and TX byte.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, minimum idle cycles between frames, legal range 1..15.
REQ-003 SHALL have port rclk  input  1  read-domain clock; the block has one clock only.
REQ-004 SHALL have port rrst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rempty  input  1  FIFO empty flag, registered in the rclk domain.
REQ-006 SHALL have port rdata  input  DATA_WIDTH  FIFO head data, valid while rempty=0.
REQ-007 SHALL have port rinc  output  1  FIFO pop strobe.
REQ-008 SHALL have port tx_busy  input  1  UART TX busy, rclk domain.
REQ-009 SHALL have port tx_data  output  DATA_WIDTH  byte presented to UART TX.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid request.
REQ-011 SHALL have port fetch_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, SEND, WAIT_DONE and GAP, using registered state.
REQ-013 In IDLE with rempty=0 and tx_busy=0 at edge k, the block SHALL, in one step: latch tx_data<=rdata, drive rinc=1 and tx_valid=1, and enter SEND.
REQ-014 The conditions in REQ-013 SHALL give one cycle of latency from the edge that samples them to tx_valid=1.
REQ-015 rinc SHALL be registered and high for exactly one cycle per fetched byte, never twice for one byte.
REQ-016 In IDLE with rempty=1 or tx_busy=1, the block SHALL stay in IDLE, with rinc=0 and tx_valid=0.
REQ-017 In SEND, tx_valid SHALL stay high and tx_data stable until tx_busy=1 is sampled.
REQ-018 On that sample (REQ-017), tx_valid SHALL drop on the next edge and the FSM SHALL enter WAIT_DONE.
REQ-019 In WAIT_DONE, the FSM SHALL stay while tx_busy=1.
REQ-020 On sampling tx_busy=0 in WAIT_DONE, the FSM SHALL enter GAP with a 4-bit counter loaded to GAP_CYCLES-1.
REQ-021 In GAP, the counter SHALL decrement once per cycle, and the FSM SHALL return to IDLE when it reaches 0.
REQ-022 From REQ-020 and REQ-021, exactly GAP_CYCLES cycles SHALL be spent in GAP.
REQ-023 tx_data SHALL hold its last value outside SEND and SHALL change only on a REQ-013 transition.
REQ-024 rempty changes outside IDLE SHALL be ignored; a stale rempty=0 after a pop SHALL NOT cause a second pop, because GAP_CYCLES>=1 guarantees that.
REQ-025 A FIFO draining to empty on the last pop SHALL complete that frame normally, then stay in IDLE.
REQ-026 fetch_busy SHALL be a decode of the registered state, with no combinational path from inputs.

Reset
REQ-027 rrst_n low SHALL asynchronously force: state=IDLE, rinc=0, tx_valid=0, tx_data=0, gap counter=0, fetch_busy=0.
REQ-028 Reset mid-frame (any state) SHALL abandon the in-flight byte without another pop.
REQ-029 After reset deassertion, the first pop SHALL occur no earlier than the second rclk edge.

Structure
REQ-030 State encodings (IDLE=2'b00, SEND=2'b01, WAIT_DONE=2'b10, GAP=2'b11) SHALL reside in the shared system constants package used by the FIFO and UART blocks.
REQ-031 No sub-module SHALL be instantiated; the FSM, data register and gap counter SHALL be one module.
REQ-032 All outputs SHALL be flop outputs.

Verification
REQ-033 The bench SHALL cover a single byte: rempty 1->0, rdata=8'hA5, tx_busy=0 -> one cycle later rinc=1 (1 cycle), tx_valid=1, tx_data=8'hA5; tx_busy raised 3 cycles later -> tx_valid=0 next edge.
REQ-034 The bench SHALL cover back-to-back bytes: FIFO holds 8'h11,8'h22,8'h33, UART busy 10 cycles/frame, GAP_CYCLES=2 -> three rinc pulses, bytes in order, at least 2 idle cycles between tx_busy falling and the next tx_valid.
REQ-035 The bench SHALL cover an idle UART busy: rempty=0 while tx_busy=1 in IDLE for 5 cycles -> no rinc and no tx_valid until tx_busy=0, then a pop on the next edge.
REQ-036 The bench SHALL cover a drain to empty: 1 byte, rempty rises the cycle after rinc -> frame completes, FSM returns to IDLE, no further rinc for 20 cycles.
REQ-037 The bench SHALL cover reset mid-frame: assert rrst_n=0 in WAIT_DONE -> all outputs 0 immediately (asynchronous); after release with rempty=0, the next byte is popped normally.
REQ-038 The bench SHALL cover slow handshake: tx_busy held 0 for 50 cycles in SEND -> tx_valid held 1, tx_data stable, rinc pulsed once only.

Source files
------------

// File: rtl/fifo_tx_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : fifo_tx_fetch_pkg                                             |
// | Purpose  : System constants shared by the FIFO, UART and the FIFO->TX    |
// |            fetch engine: fetch FSM state encoding and gap counter width. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package fifo_tx_fetch_pkg;

   // Fetch FSM state encoding. Other blocks decode these values, so they are
   // pinned explicitly.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_SEND      = 2'b01,
      ST_WAIT_DONE = 2'b10,
      ST_GAP       = 2'b11
   } fetch_state_t;

   // Inter-frame gap counter width; bounds GAP_CYCLES to 1..15.
   localparam int C_GAP_CNT_W = 4;

endpackage : fifo_tx_fetch_pkg
`default_nettype wire

// File: rtl/fifo_tx_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_tx_fetch                                                 |
// | Purpose  : Pops bytes from an rclk-domain FIFO and hands them one at a   |
// |            time to a UART transmitter, enforcing a minimum idle gap      |
// |            between frames.                                               |
// | Ports    : rclk       - single clock (FIFO read domain)                  |
// |            rrst_n     - asynchronous active-low reset                    |
// |            rempty     - FIFO empty flag (registered)                     |
// |            rdata      - FIFO head data, valid while rempty=0             |
// |            rinc       - FIFO pop strobe, one cycle per fetched byte      |
// |            tx_busy    - UART TX busy                                     |
// |            tx_data    - byte presented to the UART                       |
// |            tx_valid   - tx_data request, held until tx_busy is seen      |
// |            fetch_busy - high whenever the FSM is not idle                |
// | Params   : DATA_WIDTH (default 8), GAP_CYCLES (default 2, legal 1..15)   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fifo_tx_fetch
   import fifo_tx_fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  rempty,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  rinc,
   input  logic                  tx_busy,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  fetch_busy
);

   localparam logic [C_GAP_CNT_W-1:0] C_GAP_LOAD = C_GAP_CNT_W'(GAP_CYCLES - 1);

   fetch_state_t           r_state;
   fetch_state_t           w_state_next;
   logic [C_GAP_CNT_W-1:0] r_gap_cnt;
   logic [C_GAP_CNT_W-1:0] w_gap_cnt_next;
   logic                   w_fetch;
   // Clears on reset and sets on the first clock edge afterwards, so the
   // earliest possible pop is on the second edge after reset release.
   logic                   r_armed;

   // ------------------------------------------------------------------
   // Next-state and fetch decision
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next   = r_state;
      w_gap_cnt_next = r_gap_cnt;
      w_fetch        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_armed && !rempty && !tx_busy) begin
               w_fetch      = 1'b1;
               w_state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_busy) begin
               w_state_next = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               w_state_next   = ST_GAP;
               w_gap_cnt_next = C_GAP_LOAD;
            end
         end
         ST_GAP: begin
            // Loaded with GAP_CYCLES-1 and leaving on zero gives exactly
            // GAP_CYCLES cycles here; counter is back at zero in IDLE.
            if (r_gap_cnt == '0) begin
               w_state_next = ST_IDLE;
            end else begin
               w_gap_cnt_next = r_gap_cnt - 1'b1;
            end
         end
         default: begin
            w_state_next   = ST_IDLE;
            w_gap_cnt_next = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State register and flopped outputs
   // ------------------------------------------------------------------
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_state    <= ST_IDLE;
         r_gap_cnt  <= '0;
         r_armed    <= 1'b0;
         rinc       <= 1'b0;
         tx_valid   <= 1'b0;
         tx_data    <= '0;
         fetch_busy <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_gap_cnt  <= w_gap_cnt_next;
         r_armed    <= 1'b1;
         rinc       <= w_fetch;
         tx_valid   <= (w_state_next == ST_SEND);
         fetch_busy <= (w_state_next != ST_IDLE);
         if (w_fetch) begin
            tx_data <= rdata;
         end
      end
   end

endmodule : fifo_tx_fetch
`default_nettype wire

// File: tb/tb_fifo_tx_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fifo_tx_fetch                                              |
// | Purpose  : Self-checking bench for fifo_tx_fetch. A FIFO model serves    |
// |            rdata/rempty, directed sequences drive tx_busy, and a monitor |
// |            matches every new tx_valid frame against an expected queue.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fifo_tx_fetch;

   localparam int DATA_WIDTH = 8;
   localparam int GAP_CYCLES = 2;

   logic                  rclk = 1'b0;
   logic                  rrst_n;
   logic                  rempty;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rinc;
   logic                  tx_busy;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  fetch_busy;

   int checks = 0;
   int errors = 0;
   int rinc_count = 0;

   logic [DATA_WIDTH-1:0] fifo_q[$];
   logic [DATA_WIDTH-1:0] exp_q[$];

   fifo_tx_fetch #(
      .DATA_WIDTH (DATA_WIDTH),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .rempty     (rempty),
      .rdata      (rdata),
      .rinc       (rinc),
      .tx_busy    (tx_busy),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .fetch_busy (fetch_busy)
   );

   always #5 rclk = ~rclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Push a byte into the FIFO model and record it as an expected frame.
   task automatic push(input logic [DATA_WIDTH-1:0] d);
      fifo_q.push_back(d);
      exp_q.push_back(d);
      rempty = 1'b0;
      rdata  = fifo_q[0];
   endtask

   // Bounded wait (from a negedge) for tx_valid.
   task automatic wait_valid();
      int n;
      n = 0;
      while (!tx_valid && n < 100) begin
         @(negedge rclk);
         n++;
      end
      check("valid_timeout", 32'(n < 100), 32'd1);
   endtask

   // FIFO model: a pop strobe seen at a negedge removes the head.
   initial begin
      forever begin
         @(negedge rclk);
         if (rinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
         rempty = (fifo_q.size() == 0);
         rdata  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      end
   end

   // Monitor / scoreboard.
   initial begin
      logic prev_valid;
      logic prev_rinc;
      prev_valid = 1'b0;
      prev_rinc  = 1'b0;
      forever begin
         @(negedge rclk);
         if (rinc) begin
            rinc_count++;
            check("rinc_single_cycle", 32'(prev_rinc), 32'd0);
         end
         if (tx_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_frame actual=%0h required=none", tx_data);
            end else begin
               check("sb_data", 32'(tx_data), 32'(exp_q.pop_front()));
            end
         end
         prev_valid = tx_valid;
         prev_rinc  = rinc;
      end
   end

   initial begin
      int n;
      rrst_n  = 1'b0;
      rempty  = 1'b1;
      rdata   = '0;
      tx_busy = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) @(negedge rclk);
      check("rst_rinc", 32'(rinc), 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_fetch_busy", 32'(fetch_busy), 32'd0);
      rrst_n = 1'b1;
      repeat (4) @(negedge rclk);

      // ---------------- single byte ----------------
      rinc_count = 0;
      push(8'hA5);
      @(negedge rclk);
      check("t1_rinc", 32'(rinc), 32'd1);
      check("t1_valid", 32'(tx_valid), 32'd1);
      check("t1_data", 32'(tx_data), 32'hA5);
      check("t1_fetch_busy", 32'(fetch_busy), 32'd1);
      @(negedge rclk);
      check("t1_rinc_drop", 32'(rinc), 32'd0);
      check("t1_valid_hold", 32'(tx_valid), 32'd1);
      repeat (2) @(negedge rclk);
      tx_busy = 1'b1;
      @(negedge rclk);
      check("t1_valid_drop", 32'(tx_valid), 32'd0);
      check("t1_busy_wait", 32'(fetch_busy), 32'd1);
      repeat (3) @(negedge rclk);
      tx_busy = 1'b0;
      repeat (2) @(negedge rclk);
      check("t1_in_gap", 32'(fetch_busy), 32'd1);
      @(negedge rclk);
      check("t1_back_idle", 32'(fetch_busy), 32'd0);
      check("t1_rinc_count", 32'(rinc_count), 32'd1);
      repeat (3) @(negedge rclk);

      // ---------------- back-to-back bytes ----------------
      rinc_count = 0;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      for (int i = 0; i < 3; i++) begin
         wait_valid();
         @(negedge rclk);
         tx_busy = 1'b1;
         repeat (10) @(negedge rclk);
         tx_busy = 1'b0;
         if (i < 2) begin
            n = 0;
            do begin
               @(negedge rclk);
               n++;
            end while (!tx_valid && n < 50);
            // busy low -> GAP, 2 GAP cycles, IDLE, fetch: valid on 4th negedge
            check("t2_gap_latency", 32'(n), 32'd4);
         end
      end
      repeat (8) @(negedge rclk);
      check("t2_rinc_count", 32'(rinc_count), 32'd3);
      check("t2_idle", 32'(fetch_busy), 32'd0);

      // ---------------- UART busy while idle ----------------
      rinc_count = 0;
      tx_busy = 1'b1;
      push(8'h44);
      for (int i = 0; i < 5; i++) begin
         @(negedge rclk);
         check("t3_no_rinc", 32'(rinc), 32'd0);
         check("t3_no_valid", 32'(tx_valid), 32'd0);
      end
      tx_busy = 1'b0;
      @(negedge rclk);
      check("t3_pop", 32'(rinc), 32'd1);
      check("t3_valid", 32'(tx_valid), 32'd1);
      tx_busy = 1'b1;
      repeat (3) @(negedge rclk);
      tx_busy = 1'b0;
      repeat (6) @(negedge rclk);
      check("t3_rinc_count", 32'(rinc_count), 32'd1);

      // ---------------- drain to empty ----------------
      rinc_count = 0;
      push(8'h55);
      wait_valid();
      @(negedge rclk);
      check("t4_empty_after_pop", 32'(rempty), 32'd1);
      tx_busy = 1'b1;
      repeat (4) @(negedge rclk);
      tx_busy = 1'b0;
      repeat (20) @(negedge rclk);
      check("t4_rinc_count", 32'(rinc_count), 32'd1);
      check("t4_idle", 32'(fetch_busy), 32'd0);

      // ---------------- reset mid-frame ----------------
      rinc_count = 0;
      push(8'h66);
      push(8'h77);
      wait_valid();
      @(negedge rclk);
      tx_busy = 1'b1;
      repeat (3) @(negedge rclk);
      check("t5_in_wait_done", 32'(fetch_busy), 32'd1);
      rrst_n = 1'b0;
      #1;
      check("t5_rst_rinc", 32'(rinc), 32'd0);
      check("t5_rst_valid", 32'(tx_valid), 32'd0);
      check("t5_rst_data", 32'(tx_data), 32'd0);
      check("t5_rst_fetch_busy", 32'(fetch_busy), 32'd0);
      tx_busy = 1'b0;
      @(negedge rclk);
      rrst_n = 1'b1;
      @(negedge rclk);
      check("t5_no_pop_first_edge", 32'(rinc), 32'd0);
      @(negedge rclk);
      check("t5_pop_second_edge", 32'(rinc), 32'd1);
      check("t5_data", 32'(tx_data), 32'h77);
      tx_busy = 1'b1;
      repeat (3) @(negedge rclk);
      tx_busy = 1'b0;
      repeat (6) @(negedge rclk);
      check("t5_rinc_count", 32'(rinc_count), 32'd2);

      // ---------------- slow handshake ----------------
      rinc_count = 0;
      push(8'h88);
      wait_valid();
      for (int i = 0; i < 50; i++) begin
         @(negedge rclk);
         check("t6_valid_held", 32'(tx_valid), 32'd1);
         check("t6_data_stable", 32'(tx_data), 32'h88);
      end
      check("t6_rinc_count", 32'(rinc_count), 32'd1);
      tx_busy = 1'b1;
      repeat (3) @(negedge rclk);
      tx_busy = 1'b0;
      repeat (6) @(negedge rclk);
      check("t6_idle", 32'(fetch_busy), 32'd0);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fifo_tx_fetch
`default_nettype wire
